// File: rtl/lathe_ctrl_pkg.sv
// lathe_ctrl_pkg: mode encodings, channel state type and default widths shared by the lathe timer controller
package lathe_ctrl_pkg;
  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_MAN = 2'b01;
  localparam logic [1:0] MODE_TON = 2'b10;
  localparam logic [1:0] MODE_TOF = 2'b11;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [2:0] {ST_IDLE, ST_DON, ST_ACT, ST_DOFF, ST_LOCK} ch_state_t;
endpackage

// File: rtl/lathe_ch_timer.sv
// lathe_ch_timer: one channel mode FSM with delay counter and preset compare
module lathe_ch_timer
  import lathe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ena,
  input  logic             i_tick,
  input  logic             i_estop,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_on_pre,
  input  logic [CNT_W-1:0] i_off_pre,
  output logic             o_ctrl,
  output logic             o_busy,
  output logic             o_lockout
);
  ch_state_t r_st, w_st;
  logic [CNT_W-1:0] r_cnt, w_cnt, w_inc;
  logic [1:0] r_mode;
  logic r_ctrl, w_on_hit, w_off_hit, w_mchg;
  assign w_inc = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
  // widened compare so cnt+1 cannot wrap at the saturation value
  assign w_on_hit = ({1'b0, r_cnt} + (CNT_W+1)'(1)) >= {1'b0, i_on_pre};
  assign w_off_hit = ({1'b0, r_cnt} + (CNT_W+1)'(1)) >= {1'b0, i_off_pre};
  assign w_mchg = i_mode != r_mode;
  always_comb begin
    w_st = r_st;
    w_cnt = r_cnt;
    case (r_st)
      ST_IDLE: if (i_start && i_mode != MODE_OFF) begin
        w_st = (i_mode == MODE_TON && i_on_pre != '0) ? ST_DON : ST_ACT;
        w_cnt = '0;
      end
      ST_DON: if (!i_start) begin
        w_st = ST_IDLE;
        w_cnt = '0;
      end else if (i_tick) begin
        w_st = w_on_hit ? ST_ACT : ST_DON;
        w_cnt = w_on_hit ? '0 : w_inc;
      end
      ST_ACT: if (!i_start) begin
        w_st = (i_mode == MODE_TOF && i_off_pre != '0) ? ST_DOFF : ST_IDLE;
        w_cnt = '0;
      end
      ST_DOFF: if (i_start) begin
        w_st = ST_ACT;
        w_cnt = '0;
      end else if (i_tick) begin
        w_st = w_off_hit ? ST_IDLE : ST_DOFF;
        w_cnt = w_off_hit ? '0 : w_inc;
      end
      ST_LOCK: if (!i_estop && !i_start) w_st = ST_IDLE;
      default: w_st = ST_IDLE;
    endcase
    if (w_mchg && r_st != ST_IDLE && r_st != ST_LOCK) begin
      w_st = ST_IDLE;
      w_cnt = '0;
    end
    if (i_estop) begin
      w_st = ST_LOCK;
      w_cnt = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st <= ST_IDLE;
      r_cnt <= '0;
      r_mode <= MODE_OFF;
      r_ctrl <= 1'b0;
    end else if (i_ena) begin
      r_st <= w_st;
      r_cnt <= w_cnt;
      r_mode <= i_mode;
      r_ctrl <= (w_st == ST_ACT) || (w_st == ST_DOFF);
    end
  end
  assign o_ctrl = r_ctrl;
  assign o_busy = (r_st == ST_DON) || (r_st == ST_DOFF);
  assign o_lockout = r_st == ST_LOCK;
endmodule

// File: rtl/lathe_multi_timer_ctrl.sv
// lathe_multi_timer_ctrl: N-channel mode-selectable contactor timer with tick prescaler,
// programmable presets and global e-stop lockout
module lathe_multi_timer_ctrl
  import lathe_ctrl_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TICK_DIV = 50000,
  parameter int DEF_ON = 3000,
  parameter int DEF_OFF = 2000,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ena,
  input  logic [N_CH-1:0]   i_start,
  input  logic [2*N_CH-1:0] i_mode,
  input  logic              i_estop,
  input  logic              i_cfg_we,
  input  logic [CW-1:0]     i_cfg_ch,
  input  logic              i_cfg_sel,
  input  logic [CNT_W-1:0]  i_cfg_data,
  input  logic              i_fault_clr,
  output logic [N_CH-1:0]   o_ctrl,
  output logic [N_CH-1:0]   o_busy,
  output logic [N_CH-1:0]   o_lockout,
  output logic              o_fault
);
  logic [PW-1:0] r_pre;
  logic r_fault, w_tick;
  assign w_tick = r_pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_fault <= 1'b0;
    end else if (i_ena) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      r_fault <= i_estop || (r_fault && !i_fault_clr);
    end
  end
  assign o_fault = r_fault;
  // out-of-range cfg_ch values match no channel, so such writes fall away
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_on, r_off;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_on <= CNT_W'(DEF_ON);
        r_off <= CNT_W'(DEF_OFF);
      end else if (i_ena && i_cfg_we && i_cfg_ch == CW'(g)) begin
        if (i_cfg_sel) r_off <= i_cfg_data;
        else r_on <= i_cfg_data;
      end
    end
    lathe_ch_timer #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .reset(reset),
      .i_ena(i_ena),
      .i_tick(w_tick),
      .i_estop(i_estop),
      .i_start(i_start[g]),
      .i_mode(i_mode[2*g +: 2]),
      .i_on_pre(r_on),
      .i_off_pre(r_off),
      .o_ctrl(o_ctrl[g]),
      .o_busy(o_busy[g]),
      .o_lockout(o_lockout[g])
    );
  end
endmodule

// File: tb/tb_lathe_multi_timer_ctrl.sv
// tb_lathe_multi_timer_ctrl: directed scenario tasks plus a randomized run against a mode-level reference model
module tb_lathe_multi_timer_ctrl;
  import lathe_ctrl_pkg::*;
  logic clk = 1'b0, reset = 1'b1, ena = 1'b0, estop = 1'b0;
  logic cfg_we = 1'b0, cfg_sel = 1'b0, fault_clr = 1'b0;
  logic [3:0] start = '0;
  logic [7:0] mode = '0;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_data = '0;
  logic [3:0] ctrl, busy, lockout;
  logic fault;
  logic [2:0] ctrl3, busy3, lockout3;
  logic fault3;
  int checks = 0, errors = 0;
  localparam int P_IDLE = 0, P_WON = 1, P_ON = 2, P_WOFF = 3, P_LOCK = 4;
  int ph[4], el[4], pm[4], mon[4], moff[4];
  bit mfault;

  always #5 clk = ~clk;

  lathe_multi_timer_ctrl #(.N_CH(4), .CNT_W(16), .TICK_DIV(1), .DEF_ON(3000), .DEF_OFF(2000)) u_dut (
    .clk(clk), .reset(reset), .i_ena(ena), .i_start(start), .i_mode(mode), .i_estop(estop),
    .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .i_fault_clr(fault_clr), .o_ctrl(ctrl), .o_busy(busy), .o_lockout(lockout), .o_fault(fault)
  );

  lathe_multi_timer_ctrl #(.N_CH(3), .CNT_W(16), .TICK_DIV(1), .DEF_ON(3000), .DEF_OFF(2000)) u_dut3 (
    .clk(clk), .reset(reset), .i_ena(ena), .i_start(start[2:0]), .i_mode(mode[5:0]), .i_estop(estop),
    .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .i_fault_clr(fault_clr), .o_ctrl(ctrl3), .o_busy(busy3), .o_lockout(lockout3), .o_fault(fault3)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ena = 1'b1; estop = 1'b0; cfg_we = 1'b0; fault_clr = 1'b0;
    start = '0; mode = '0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic wr(input int ch, input logic sel, input int val);
    cfg_ch = 2'(ch); cfg_sel = sel; cfg_data = 16'(val); cfg_we = 1'b1;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ctrl, busy, lockout, fault, ctrl3, lockout3, fault3} !== 20'h0) begin
      errors++; $display("FAIL reset_outs got=%h exp=0", {ctrl, busy, lockout, fault, ctrl3, lockout3, fault3});
    end
    mode[1:0] = MODE_TON; start[0] = 1'b1;
    cyc(5);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got=%b exp=1", busy[0]); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ctrl, busy, lockout, fault} !== 13'h0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", {ctrl, busy, lockout, fault});
    end
    cyc(1);
    reset = 1'b0;
    cyc(3000);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b01) begin errors++; $display("FAIL def_on_2999 got=%b exp=01", {ctrl[0], busy[0]}); end
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL def_on_3000 got=%b exp=10", {ctrl[0], busy[0]}); end
    mode[3:2] = MODE_TOF; start[1] = 1'b1;
    cyc(1);
    start[1] = 1'b0;
    cyc(2000);
    checks++;
    if (ctrl[1] !== 1'b1) begin errors++; $display("FAIL def_off_1999 got=%b exp=1", ctrl[1]); end
    cyc(1);
    checks++;
    if (ctrl[1] !== 1'b0) begin errors++; $display("FAIL def_off_2000 got=%b exp=0", ctrl[1]); end
  endtask

  task automatic test_ton();
    do_reset();
    wr(0, 1'b0, 20);
    mode[1:0] = MODE_TON; start[0] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      cyc(1);
      checks++;
      if ({ctrl[0], busy[0]} !== (k < 20 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL ton_edge%0d got=%b exp=%b", k, {ctrl[0], busy[0]}, (k < 20 ? 2'b01 : 2'b10));
      end
    end
    start[0] = 1'b0;
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL ton_release got=%b exp=00", {ctrl[0], busy[0]}); end
    start[0] = 1'b1;
    cyc(10);
    start[0] = 1'b0;
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL ton_abort got=%b exp=00", {ctrl[0], busy[0]}); end
    cyc(15);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL ton_abort_late got=%b exp=00", {ctrl[0], busy[0]}); end
  endtask

  task automatic test_tof();
    do_reset();
    wr(1, 1'b1, 5);
    mode[3:2] = MODE_TOF; start[1] = 1'b1;
    cyc(1);
    checks++;
    if ({ctrl[1], busy[1]} !== 2'b10) begin errors++; $display("FAIL tof_on got=%b exp=10", {ctrl[1], busy[1]}); end
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        start[1] = 1'b0;
        cyc(3);
        start[1] = 1'b1;
        cyc(1);
        checks++;
        if ({ctrl[1], busy[1]} !== 2'b10) begin errors++; $display("FAIL tof_reassert got=%b exp=10", {ctrl[1], busy[1]}); end
      end
      start[1] = 1'b0;
      for (int k = 0; k <= 5; k++) begin
        cyc(1);
        checks++;
        if ({ctrl[1], busy[1]} !== (k < 5 ? 2'b11 : 2'b00)) begin
          errors++; $display("FAIL tof_r%0d_edge%0d got=%b exp=%b", r, k, {ctrl[1], busy[1]}, (k < 5 ? 2'b11 : 2'b00));
        end
      end
    end
  endtask

  task automatic test_estop();
    do_reset();
    wr(3, 1'b0, 2);
    mode = {MODE_TON, MODE_MAN, MODE_OFF, MODE_OFF}; start = 4'b1100;
    cyc(3);
    checks++;
    if (ctrl !== 4'b1100) begin errors++; $display("FAIL estop_pre_ctrl got=%b exp=1100", ctrl); end
    estop = 1'b1;
    cyc(1);
    checks++;
    if ({ctrl, busy, lockout, fault} !== {4'b0000, 4'b0000, 4'b1111, 1'b1}) begin
      errors++; $display("FAIL estop_lock got=%b exp=0000000011111", {ctrl, busy, lockout, fault});
    end
    estop = 1'b0; start = 4'b0100;
    cyc(1);
    checks++;
    if ({ctrl, lockout, fault} !== {4'b0000, 4'b0100, 1'b1}) begin
      errors++; $display("FAIL estop_hold got=%b exp=000001001", {ctrl, lockout, fault});
    end
    estop = 1'b1; fault_clr = 1'b1;
    cyc(1);
    checks++;
    if ({lockout, fault} !== 5'b11111) begin errors++; $display("FAIL estop_clr_blocked got=%b exp=11111", {lockout, fault}); end
    estop = 1'b0;
    cyc(1);
    checks++;
    if ({lockout, fault} !== 5'b01000) begin errors++; $display("FAIL fault_clr got=%b exp=01000", {lockout, fault}); end
    fault_clr = 1'b0; start = 4'b0000;
    cyc(1);
    checks++;
    if (lockout !== 4'b0000) begin errors++; $display("FAIL lock_exit got=%b exp=0000", lockout); end
    start = 4'b0100;
    cyc(1);
    checks++;
    if ({ctrl, fault} !== 5'b01000) begin errors++; $display("FAIL man_after_lock got=%b exp=01000", {ctrl, fault}); end
  endtask

  task automatic test_preset_lower();
    do_reset();
    wr(0, 1'b0, 100);
    mode[1:0] = MODE_TON; start[0] = 1'b1;
    cyc(51);
    wr(0, 1'b0, 10);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b01) begin errors++; $display("FAIL lower_write_edge got=%b exp=01", {ctrl[0], busy[0]}); end
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL lower_next_edge got=%b exp=10", {ctrl[0], busy[0]}); end
  endtask

  task automatic test_cfg_ignore();
    do_reset();
    mode[5:4] = MODE_TON;
    wr(3, 1'b0, 0);
    start[2] = 1'b1;
    cyc(4);
    checks++;
    if ({ctrl3[2], busy3[2]} !== 2'b01) begin errors++; $display("FAIL cfg_oob_ignored got=%b exp=01", {ctrl3[2], busy3[2]}); end
    start[2] = 1'b0;
    wr(2, 1'b0, 2);
    start[2] = 1'b1;
    cyc(2);
    checks++;
    if (ctrl3[2] !== 1'b0) begin errors++; $display("FAIL cfg_valid_edge1 got=%b exp=0", ctrl3[2]); end
    cyc(1);
    checks++;
    if (ctrl3[2] !== 1'b1) begin errors++; $display("FAIL cfg_valid_edge2 got=%b exp=1", ctrl3[2]); end
  endtask

  task automatic test_ena();
    do_reset();
    wr(0, 1'b0, 20);
    mode[1:0] = MODE_TON; start[0] = 1'b1;
    cyc(5);
    ena = 1'b0; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_data = 16'd1;
    cyc(7);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b01) begin errors++; $display("FAIL ena_freeze got=%b exp=01", {ctrl[0], busy[0]}); end
    cfg_we = 1'b0; ena = 1'b1;
    cyc(15);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b01) begin errors++; $display("FAIL ena_shift_19 got=%b exp=01", {ctrl[0], busy[0]}); end
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL ena_shift_20 got=%b exp=10", {ctrl[0], busy[0]}); end
    start[0] = 1'b0;
    cyc(1);
    start[0] = 1'b1;
    cyc(5);
    mode[1:0] = MODE_MAN;
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL mode_chg_idle got=%b exp=00", {ctrl[0], busy[0]}); end
    cyc(1);
    checks++;
    if ({ctrl[0], busy[0]} !== 2'b10) begin errors++; $display("FAIL mode_chg_man got=%b exp=10", {ctrl[0], busy[0]}); end
  endtask

  // mode-level view of a channel: what the operator expects each edge given its mode and start
  function automatic void model_step();
    int m;
    bit s, chg;
    if (!ena) return;
    for (int c = 0; c < 4; c++) begin
      m = int'(mode[2*c +: 2]);
      s = start[c];
      chg = (m != pm[c]);
      pm[c] = m;
      if (estop) begin ph[c] = P_LOCK; el[c] = 0; end
      else if (ph[c] == P_LOCK) begin if (!s) ph[c] = P_IDLE; end
      else if (chg && ph[c] != P_IDLE) begin ph[c] = P_IDLE; el[c] = 0; end
      else if (m == int'(MODE_MAN)) ph[c] = s ? P_ON : P_IDLE;
      else if (m == int'(MODE_TON)) begin
        if (!s) begin ph[c] = P_IDLE; el[c] = 0; end
        else if (ph[c] == P_IDLE) begin ph[c] = (mon[c] == 0) ? P_ON : P_WON; el[c] = 0; end
        else if (ph[c] == P_WON) begin el[c]++; if (el[c] >= mon[c]) ph[c] = P_ON; end
      end else if (m == int'(MODE_TOF)) begin
        if (s) begin ph[c] = P_ON; el[c] = 0; end
        else if (ph[c] == P_ON) begin ph[c] = (moff[c] == 0) ? P_IDLE : P_WOFF; el[c] = 0; end
        else if (ph[c] == P_WOFF) begin el[c]++; if (el[c] >= moff[c]) ph[c] = P_IDLE; end
      end else ph[c] = P_IDLE;
    end
    mfault = estop || (mfault && !fault_clr);
    if (cfg_we) begin
      if (cfg_sel) moff[cfg_ch] = int'(cfg_data);
      else mon[cfg_ch] = int'(cfg_data);
    end
  endfunction

  task automatic test_random();
    logic [12:0] exp_v;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      ph[c] = P_IDLE; el[c] = 0; pm[c] = 0; mon[c] = 3000; moff[c] = 2000;
    end
    mfault = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(9) != 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(3) == 0) start[c] = ~start[c];
        if ($urandom_range(39) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
      end
      estop = estop ? ($urandom_range(2) != 0) : ($urandom_range(79) == 0);
      fault_clr = ($urandom_range(7) == 0);
      cfg_we = ($urandom_range(5) == 0);
      cfg_ch = 2'($urandom_range(3));
      cfg_sel = 1'($urandom_range(1));
      cfg_data = 16'($urandom_range(8));
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < 4; c++) begin
        exp_v[9+c] = (ph[c] == P_ON) || (ph[c] == P_WOFF);
        exp_v[5+c] = (ph[c] == P_WON) || (ph[c] == P_WOFF);
        exp_v[1+c] = (ph[c] == P_LOCK);
      end
      exp_v[0] = mfault;
      checks++;
      if ({ctrl, busy, lockout, fault} !== exp_v) begin
        errors++; $display("FAIL random_cyc%0d got=%b exp=%b", i, {ctrl, busy, lockout, fault}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ton();
    test_tof();
    test_estop();
    test_preset_lower();
    test_cfg_ignore();
    test_ena();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
